fpadd_share_ctrl: RTL and testbench

- Round-robin controller that shares one combinational FP32 adder datapath between NUM_REQ requesters.
- Each requester uses its own valid/ready request channel and valid/ready response channel.
- The block arbitrates, latches operands and holds them stable on the adder inputs for ADD_LAT cycles, then captures and classifies the sum and returns it to the granted requester.
- It sits between the requester-side logic and the adder top (align/add/normalize).

---
 rtl/fpadd_share_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fpadd_share_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_share_ctrl.sv
// Round-robin controller sharing one combinational FP32 adder among NUM_REQ requesters.
// Optional statistics outputs (stat_ops/stat_nan/stat_wait) are built when FPADD_SHARE_STATS_EN is defined.
module fpadd_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_result,
    output logic [2:0]             rsp_flags,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    input  logic [31:0]            add_result,
    output logic                   busy
`ifdef FPADD_SHARE_STATS_EN
    ,
    output logic [15:0]            stat_ops,
    output logic [15:0]            stat_nan,
    output logic [15:0]            stat_wait
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW:0]          NR_W     = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0]        LAST_IDX = PW'(NUM_REQ-1);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);
    localparam logic [3:0]           CNT_INIT = 4'(ADD_LAT-1);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    // {nan, inf, zero}; denormals report all flags clear
    function automatic logic [2:0] classify(input logic [31:0] v);
        logic exp_max;
        logic exp_zero;
        logic mant_zero;
        exp_max   = (v[30:23] == 8'hFF);
        exp_zero  = (v[30:23] == 8'h00);
        mant_zero = (v[22:0] == 23'd0);
        return {exp_max & ~mant_zero, exp_max & mant_zero, exp_zero & mant_zero};
    endfunction

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        add_a_q, add_a_d;
    logic [31:0]        add_b_q, add_b_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic [2:0]         rsp_flags_q, rsp_flags_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               found_s;
    logic [PW-1:0]      win_s;

    // Round-robin search starting at rr_q, wrapping modulo NUM_REQ
    always_comb begin
        logic [PW:0] sum;
        logic [PW:0] idx;
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_q} + (PW+1)'(k);
            idx = (sum >= NR_W) ? (sum - NR_W) : sum;
            if (!found_s && req_valid[idx[PW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, operand latch and result capture
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    req_ready = ONE_HOT0 << win_s;
                    add_a_d   = req_a[{win_s, 5'd0} +: 32];
                    add_b_d   = req_b[{win_s, 5'd0} +: 32];
                    owner_d   = win_s;
                    rr_d      = (win_s == LAST_IDX) ? '0 : (win_s + 1'b1);
                    cnt_d     = CNT_INIT;
                    state_d   = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = add_result;
                    rsp_flags_d  = classify(add_result);
                    rsp_valid_d  = ONE_HOT0 << owner_q;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            owner_q      <= '0;
            cnt_q        <= 4'd0;
            add_a_q      <= 32'd0;
            add_b_q      <= 32'd0;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 3'd0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_valid  = rsp_valid_q;
    assign busy       = (state_q != IDLE);

`ifdef FPADD_SHARE_STATS_EN
    logic [15:0] ops_q, nan_q, wait_q;

    // Saturating activity counters; a nonzero wait count means an arbitration stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q  <= 16'd0;
            nan_q  <= 16'd0;
            wait_q <= 16'd0;
        end else begin
            if ((state_q == IDLE) && found_s && (ops_q != 16'hFFFF)) begin
                ops_q <= ops_q + 16'd1;
            end
            if ((state_q == EXEC) && (cnt_q == 4'd0) && rsp_flags_d[2] && (nan_q != 16'hFFFF)) begin
                nan_q <= nan_q + 16'd1;
            end
            if ((state_q == IDLE) && (|req_valid) && !found_s && (wait_q != 16'hFFFF)) begin
                wait_q <= wait_q + 16'd1;
            end
        end
    end

    assign stat_ops  = ops_q;
    assign stat_nan  = nan_q;
    assign stat_wait = wait_q;
`endif

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Self-checking bench for fpadd_share_ctrl (NUM_REQ=4, ADD_LAT=2) with a stand-in adder and response scoreboard.
module tb_fpadd_share_ctrl;
    localparam int NR  = 4;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_a = '0;
    logic [NR*32-1:0]  req_b = '0;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready = '1;
    logic [31:0]       rsp_result;
    logic [2:0]        rsp_flags;
    logic [31:0]       add_a, add_b, add_result;
    logic              busy;
`ifdef FPADD_SHARE_STATS_EN
    logic [15:0]       stat_ops, stat_nan, stat_wait;
`endif

    fpadd_share_ctrl #(.NUM_REQ(NR), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .add_a(add_a), .add_b(add_b), .add_result(add_result), .busy(busy)
`ifdef FPADD_SHARE_STATS_EN
        , .stat_ops(stat_ops), .stat_nan(stat_nan), .stat_wait(stat_wait)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in adder: known IEEE sums for the special cases, integer sum otherwise
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (a == 32'h7F800000 && b == 32'hFF800000) return 32'h7FFFFFFF;
        if (a == 32'h7F800000 && b == 32'h3F800000) return 32'h7F800000;
        if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h00000000;
        return a + b;
    endfunction
    always_comb add_result = fake_add(add_a, add_b);

    typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [2:0] flg; } vec_t;
    typedef struct { int idx; logic [31:0] res; logic [2:0] flg; } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [3:0]  oh;
    logic [31:0] pend_res [NR];
    logic [2:0]  pend_flg [NR];
    int total = 0;
    int bad   = 0;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) sb.push_back('{i, pend_res[i], pend_flg[i]});
            if (|(rsp_valid & rsp_ready)) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
                end else begin
                    e  = sb.pop_front();
                    oh = 4'b0001 << e.idx;
                    check("rsp_owner", {28'd0, rsp_valid}, {28'd0, oh});
                    check("rsp_result", rsp_result, e.res);
                    check("rsp_flags", {29'd0, rsp_flags}, {29'd0, e.flg});
                end
            end
        end
    end

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [2:0] flg);
        pend_res[idx] = res;
        pend_flg[idx] = flg;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_valid[idx] = 1'b1;
    endtask

    task automatic wait_accept(input int idx, output int c);
        bit got = 1'b0;
        c = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_valid[idx] && req_ready[idx]) begin got = 1'b1; c = cyc; end
        end
        check("accept_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_any_accept(output int widx, output int c);
        bit got = 1'b0;
        widx = -1; c = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) begin got = 1'b1; widx = i; c = cyc; end
        end
        check("any_accept_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (!busy) got = 1'b1;
        end
        check("idle_reached", {31'd0, got}, 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        int  c0;
        bit  got = 1'b0;
        logic [3:0] exp_oh;
        @(posedge clk); #1;
        set_req(v.idx, v.a, v.b, v.res, v.flg);
        wait_accept(v.idx, c0);
        exp_oh = 4'b0001 << v.idx;
        check("grant_onehot", {28'd0, req_ready}, {28'd0, exp_oh});
        @(posedge clk); #1;
        req_valid[v.idx] = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) got = 1'b1;
        end
        check("rsp_seen", {31'd0, got}, 32'd1);
        check("latency", cyc - c0, LAT + 1);
        wait_idle();
    endtask

    initial begin
        int widx, c, prev, cnt;
        tbl[0] = '{1, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000};
        tbl[1] = '{0, 32'h7F800000, 32'hFF800000, 32'h7FFFFFFF, 3'b100};
        tbl[2] = '{2, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b010};
        tbl[3] = '{3, 32'h3F800000, 32'hBF800000, 32'h00000000, 3'b001};
        tbl[4] = '{1, 32'h80000000, 32'h00000000, 32'h80000000, 3'b001};
        tbl[5] = '{2, 32'h00000001, 32'h00000002, 32'h00000003, 3'b000};
        tbl[6] = '{0, 32'h7F000000, 32'h00800000, 32'h7F800000, 3'b010};
        tbl[7] = '{3, 32'hFF800000, 32'h00400000, 32'hFFC00000, 3'b100};
        tbl[8] = '{0, 32'h40000000, 32'h00000001, 32'h40000001, 3'b000};

        // Reset values
        #12;
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_add_a", add_a, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // All four valid: grants 0,1,2,3,0 spaced ADD_LAT+2 apart
        for (int i = 0; i < NR; i++) set_req(i, 32'(i + 1), 32'h10, 32'(32'h11 + i), 3'b000);
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_any_accept(widx, c);
            check("grant_order", widx, g % NR);
            if (g > 0) check("accept_spacing", c - prev, LAT + 2);
            prev = c;
        end
        @(posedge clk); #1 req_valid = '0;
        wait_idle();

        for (int t = 0; t < 9; t++) run_op(tbl[t]);

        // Backpressure on requester 2 with requester 0 waiting
        @(posedge clk); #1 rsp_ready = 4'b1011;
        set_req(2, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b010);
        wait_accept(2, c);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        set_req(0, 32'h40000000, 32'h00000001, 32'h40000001, 3'b000);
        cnt = 0;
        for (int k = 0; k < 40 && cnt == 0; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) cnt = 1;
        end
        check("bp_rsp_seen", cnt, 1);
        for (int k = 0; k < 10; k++) begin
            check("bp_rsp_valid", {28'd0, rsp_valid}, 32'h4);
            check("bp_rsp_result", rsp_result, 32'h7F800000);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 4'b1111;
        @(negedge clk);
        check("bp_hs_req_ready", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("bp_after_req_ready", {28'd0, req_ready}, 32'h1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_idle();

        // Reset during EXEC aborts the operation
        @(posedge clk); #1;
        set_req(1, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
        wait_accept(1, c);
        @(posedge clk); #3;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("mid_rst_result", rsp_result, 32'd0);
        check("mid_rst_flags", {29'd0, rsp_flags}, 32'd0);
        check("mid_rst_add_a", add_a, 32'd0);
        check("mid_rst_add_b", add_b, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) cnt++;
        end
        check("no_rsp_after_reset", cnt, 0);

        // rr_ptr back at 0: requester 0 beats requester 3
        @(posedge clk); #1;
        set_req(0, 32'h5, 32'h10, 32'h15, 3'b000);
        set_req(3, 32'h6, 32'h10, 32'h16, 3'b000);
        wait_any_accept(widx, c);
        check("rr_after_reset", widx, 0);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_accept(3, c);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        wait_idle();
        for (int t = 1; t < 4; t++) run_op(tbl[t]);

`ifdef FPADD_SHARE_STATS_EN
        check("stat_ops", {16'd0, stat_ops}, 32'd5);
        check("stat_nan", {16'd0, stat_nan}, 32'd1);
        check("stat_wait", {16'd0, stat_wait}, 32'd0);
`endif
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
